sys_reg_ctrl: RTL and testbench

SYS_REG_CTRL -- requirements
Module: sys_reg_ctrl

---
 rtl/sys_reg_ctrl.sv | 149 ++++++++++++++
 tb/tb_sys_reg_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sys_reg_ctrl
// Description : Holds system register SR1 and sequences its three update
//               sources: execute-stage field writes, exception entry and
//               return-from-exception. A single FSM serialises the requests.
//               Optional feature macro: SYS_REG_CTRL_SHADOW_EN (adds the
//               shadow register, the EXC_SAVE state and restore-on-return).
// Revision    : 1.0 - initial release
// ============================================================================
module sys_reg_ctrl (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iEXE_REQ,
  input  logic [1:0]  iEXE_CMD,
  input  logic [31:0] iEXE_DATA,
  input  logic        iEXC_REQ,
  input  logic        iEXC_RET,
  output logic        oEXE_ACK,
  output logic        oEXC_ACK,
  output logic        oBUSY,
  output logic [31:0] oSR1,
  output logic [31:0] oSR1_SHADOW
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    EXC_SAVE = 3'd2,
    EXC_SET  = 3'd3,
    RET      = 3'd4,
    ACK      = 3'd5
  } state_t;

  localparam logic [1:0] c_MMUMOD_W = 2'd0;
  localparam logic [1:0] c_IM_W     = 2'd1;
  localparam logic [1:0] c_CMOD_W   = 2'd2;
  localparam logic [1:0] c_FULL_W   = 2'd3;

`ifdef SYS_REG_CTRL_SHADOW_EN
  // Entry must snapshot SR1 before the interrupt/mode bits are cleared.
  localparam state_t c_ENTRY_STATE = EXC_SAVE;
`else
  // Without a shadow there is nothing to save, so entry clears SR1 at once.
  localparam state_t c_ENTRY_STATE = EXC_SET;
`endif

  state_t      r_state;
  state_t      w_nextState;
  logic        w_acceptExe;
  logic [1:0]  r_cmd;
  logic [31:0] r_data;
  logic [31:0] r_sr1;

`ifdef SYS_REG_CTRL_SHADOW_EN
  logic [31:0] r_shadow;

  // Shadow captures SR1 in EXC_SAVE, before EXC_SET modifies it.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_shadow <= 32'h0000_0000;
    end else if (r_state == EXC_SAVE) begin
      r_shadow <= r_sr1;
    end
  end

  assign oSR1_SHADOW = r_shadow;
`else
  assign oSR1_SHADOW = 32'h0000_0000;
`endif

  // State register.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; IDLE arbitrates with entry > return > execute write.
  always_comb begin
    w_nextState = r_state;
    w_acceptExe = 1'b0;
    case (r_state)
      IDLE: begin
        if (iEXC_REQ) begin
          w_nextState = c_ENTRY_STATE;
        end else if (iEXC_RET) begin
          w_nextState = RET;
        end else if (iEXE_REQ) begin
          w_nextState = WRITE;
          w_acceptExe = 1'b1;
        end
      end
      WRITE:    w_nextState = IDLE;
      EXC_SAVE: w_nextState = EXC_SET;
      EXC_SET:  w_nextState = ACK;
      RET:      w_nextState = ACK;
      ACK:      w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Command latch and SR1 updates; each state touches only its own fields.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_cmd  <= 2'd0;
      r_data <= 32'h0000_0000;
      r_sr1  <= 32'h0000_0000;
    end else begin
      if (w_acceptExe) begin
        r_cmd  <= iEXE_CMD;
        r_data <= iEXE_DATA;
      end
      case (r_state)
        WRITE: begin
          case (r_cmd)
            c_MMUMOD_W: r_sr1[1:0] <= r_data[1:0];
            c_IM_W:     r_sr1[2]   <= r_data[0];
            c_CMOD_W:   r_sr1[6:5] <= r_data[1:0];
            c_FULL_W:   r_sr1      <= r_data;
          endcase
        end
        EXC_SET: begin
          r_sr1[2]   <= 1'b0;
          r_sr1[6:5] <= 2'b00;
        end
        RET: begin
`ifdef SYS_REG_CTRL_SHADOW_EN
          r_sr1 <= r_shadow;
`else
          r_sr1[2]   <= 1'b1;
          r_sr1[6:5] <= 2'b11;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign oEXE_ACK = (r_state == WRITE);
  assign oEXC_ACK = (r_state == ACK);
  assign oBUSY    = (r_state != IDLE);
  assign oSR1     = r_sr1;

endmodule
`default_nettype wire

// File: tb/tb_sys_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_reg_ctrl
// Description : Scoreboard bench for sys_reg_ctrl. Each transaction pushes the
//               expected ack kind, ack position within the busy window and the
//               resulting SR1/shadow; the monitor pops on every ack. Honours
//               SYS_REG_CTRL_SHADOW_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exeReq = 1'b0;
  logic [1:0]  exeCmd = 2'd0;
  logic [31:0] exeData = 32'h0;
  logic        excReq = 1'b0;
  logic        excRet = 1'b0;
  logic        exeAck;
  logic        excAck;
  logic        busy;
  logic [31:0] sr1;
  logic [31:0] sr1Shadow;

  typedef struct {
    int          kind;   // 0 = execute write ack, 1 = entry/return ack
    int          pos;    // busy cycle (1-based) in which the ack appears
    logic [31:0] sr1;
    logic [31:0] shadow;
  } item_t;

  item_t       sbQ[$];
  item_t       pendItem;
  bit          pend = 1'b0;
  int          busyCnt = 0;
  int          ackCnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] mSr1 = 32'h0;
  logic [31:0] mShadow = 32'h0;

`ifdef SYS_REG_CTRL_SHADOW_EN
  localparam int c_ENTRY_POS = 3;
`else
  localparam int c_ENTRY_POS = 2;
`endif

  sys_reg_ctrl dut (
    .iCLOCK      (clk),
    .iRESET      (rst),
    .iEXE_REQ    (exeReq),
    .iEXE_CMD    (exeCmd),
    .iEXE_DATA   (exeData),
    .iEXC_REQ    (excReq),
    .iEXC_RET    (excRet),
    .oEXE_ACK    (exeAck),
    .oEXC_ACK    (excAck),
    .oBUSY       (busy),
    .oSR1        (sr1),
    .oSR1_SHADOW (sr1Shadow)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model updates, applied in the order the DUT will serve the requests.
  task automatic pushExe(input logic [1:0] cmd, input logic [31:0] data);
    item_t it;
    case (cmd)
      2'd0: mSr1[1:0] = data[1:0];
      2'd1: mSr1[2]   = data[0];
      2'd2: mSr1[6:5] = data[1:0];
      2'd3: mSr1      = data;
    endcase
    it.kind = 0; it.pos = 1; it.sr1 = mSr1; it.shadow = mShadow;
    sbQ.push_back(it);
  endtask

  task automatic pushEntry();
    item_t it;
`ifdef SYS_REG_CTRL_SHADOW_EN
    mShadow = mSr1;
`endif
    mSr1[2] = 1'b0;
    mSr1[6:5] = 2'b00;
    it.kind = 1; it.pos = c_ENTRY_POS; it.sr1 = mSr1; it.shadow = mShadow;
    sbQ.push_back(it);
  endtask

  task automatic pushRet();
    item_t it;
`ifdef SYS_REG_CTRL_SHADOW_EN
    mSr1 = mShadow;
`else
    mSr1[2] = 1'b1;
    mSr1[6:5] = 2'b11;
`endif
    it.kind = 1; it.pos = 2; it.sr1 = mSr1; it.shadow = mShadow;
    sbQ.push_back(it);
  endtask

  // Monitor: pops on each ack, checks SR1/shadow one cycle later when the
  // transaction has fully settled and the block must be idle again.
  always @(negedge clk) begin
    if (pend) begin
      checkVal("sr1", sr1, pendItem.sr1);
      checkVal("shadow", sr1Shadow, pendItem.shadow);
      checkVal("busy_after", {31'b0, busy}, 32'h0);
      pend = 1'b0;
    end
    if (busy) busyCnt++;
    else busyCnt = 0;
    if (exeAck || excAck) begin
      ackCnt++;
      checkVal("dual_ack", {31'b0, exeAck & excAck}, 32'h0);
      if (sbQ.size() == 0) begin
        checkVal("unexpected_ack", 32'(sbQ.size()), 32'd1);
      end else begin
        pendItem = sbQ.pop_front();
        checkVal("ack_kind", {31'b0, excAck}, 32'(pendItem.kind));
        checkVal("ack_pos", 32'(busyCnt), 32'(pendItem.pos));
        pend = 1'b1;
      end
    end
  end

  // Hold the selected request until its ack, then drop it.
  task automatic waitAck(input int kind);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kind == 0 && exeAck) begin exeReq = 1'b0; return; end
      if (kind == 1 && excAck) begin excReq = 1'b0; excRet = 1'b0; return; end
    end
    checkVal("ack_timeout", 32'(kind), 32'hFFFF_FFFF);
    exeReq = 1'b0; excReq = 1'b0; excRet = 1'b0;
  endtask

  task automatic doExe(input logic [1:0] cmd, input logic [31:0] data);
    @(negedge clk);
    pushExe(cmd, data);
    exeCmd = cmd; exeData = data; exeReq = 1'b1;
    waitAck(0);
  endtask

  task automatic doEntry();
    @(negedge clk);
    pushEntry();
    excReq = 1'b1;
    waitAck(1);
  endtask

  task automatic doRet();
    @(negedge clk);
    pushRet();
    excRet = 1'b1;
    waitAck(1);
  endtask

  initial begin
    int savedAcks;
    bit done;

    // Reset state.
    repeat (3) @(negedge clk);
    checkVal("rst_sr1", sr1, 32'h0);
    checkVal("rst_shadow", sr1Shadow, 32'h0);
    checkVal("rst_busy", {31'b0, busy}, 32'h0);
    checkVal("rst_acks", {30'b0, exeAck, excAck}, 32'h0);
    rst = 1'b0;

    // IM write from reset, then a full write and entry/return round trip.
    doExe(2'd1, 32'h0000_0001);
    doExe(2'd3, 32'h0000_0067);
    doEntry();
    doRet();

    // CMOD write only touches bits [6:5]; MMUMOD only [1:0].
    doExe(2'd3, 32'h0000_0000);
    doExe(2'd2, 32'hFFFF_FFFF);
    doExe(2'd0, 32'hFFFF_FFFE);
    doExe(2'd1, 32'h0000_0000);

    // Return straight from SR1=0.
    doExe(2'd3, 32'h0000_0000);
    doRet();

    // A few random full/field writes.
    for (int i = 0; i < 4; i++) begin
      doExe(2'(i), $urandom());
    end

    // All three requests together: entry, then return, then write.
    doExe(2'd3, 32'hA5A5_0F7F);
    @(negedge clk);
    pushEntry();
    pushRet();
    pushExe(2'd0, 32'h0000_0001);
    exeCmd = 2'd0; exeData = 32'h0000_0001;
    excReq = 1'b1; excRet = 1'b1; exeReq = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (excAck) begin
        if (excReq) excReq = 1'b0;
        else excRet = 1'b0;
      end
      if (exeAck) exeReq = 1'b0;
      done = !(excReq || excRet || exeReq);
    end
    checkVal("prio_done", {31'b0, done}, 32'h1);
    exeReq = 1'b0; excReq = 1'b0; excRet = 1'b0;

    // Reset pulsed while in EXC_SET aborts the entry; held request restarts.
    doExe(2'd3, 32'h0000_00E7);
    doEntry();
    doExe(2'd3, 32'h0000_0067);
    @(negedge clk);
    savedAcks = ackCnt;
    excReq = 1'b1;
    repeat (c_ENTRY_POS - 1) @(negedge clk);
    rst = 1'b1;
    #2;
    checkVal("abort_sr1", sr1, 32'h0);
    checkVal("abort_shadow", sr1Shadow, 32'h0);
    checkVal("abort_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    checkVal("abort_noack", 32'(ackCnt), 32'(savedAcks));
    mSr1 = 32'h0;
    mShadow = 32'h0;
    pushEntry();
    rst = 1'b0;
    @(negedge clk);
    checkVal("restart_busy", {31'b0, busy}, 32'h1);
    waitAck(1);

    repeat (3) @(negedge clk);
    checkVal("sb_left", 32'(sbQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
